// File: rtl/nnrv_pkg.sv
// -----------------------------------------------------------------------------
// nnrv_pkg
// Shared constants for the nnrv writeback stage.
//   - Default datapath width and architectural register count.
//   - RISC-V load funct3 encodings (LB..LWU) used by the optional load extender.
//   - One-bit grant encoding for the ALU/load round-robin arbiter.
// -----------------------------------------------------------------------------
package nnrv_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int REG_NUM_DEF = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Grant encoding: the channel that won the most recent acceptance
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

endpackage

// File: rtl/nnrv_wb_ldext.sv
// -----------------------------------------------------------------------------
// nnrv_wb_ldext
// Combinational load-data extender. Sign-extends LB/LH/LW from bit 7/15/31,
// zero-extends LBU/LHU/LWU, and passes LD (and the unused 3'b111) through.
//   funct3   in  3     load type
//   data_in  in  XLEN  right-aligned load data
//   data_out out XLEN  extended load data
// -----------------------------------------------------------------------------
module nnrv_wb_ldext
    import nnrv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_LB:   data_out = {{(XLEN-8){data_in[7]}},   data_in[7:0]};
            F3_LH:   data_out = {{(XLEN-16){data_in[15]}}, data_in[15:0]};
            F3_LW:   data_out = {{(XLEN-32){data_in[31]}}, data_in[31:0]};
            F3_LBU:  data_out = {{(XLEN-8){1'b0}},         data_in[7:0]};
            F3_LHU:  data_out = {{(XLEN-16){1'b0}},        data_in[15:0]};
            F3_LWU:  data_out = {{(XLEN-32){1'b0}},        data_in[31:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/nnrv_wb.sv
// -----------------------------------------------------------------------------
// nnrv_wb
// Writeback stage of the nnrv core. Arbitrates between the ALU result channel
// and the load-return channel (round-robin on ties), optionally extends load
// data, registers a single write (enable, index, data) toward the register
// file, and keeps a per-register busy scoreboard for decode stalls.
//
// Configuration macro: NNRV_WB_LOAD_EXT_EN
//   defined   - load data extended per i_ld_funct3 (nnrv_wb_ldext)
//   undefined - load data written unmodified, i_ld_funct3 ignored
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_alu_valid/rd/data       ALU result channel;  o_alu_ready = accepted
//   i_ld_valid/rd/funct3/data load return channel; o_ld_ready  = accepted
//   i_iss_en, i_iss_rd        decode issue of an instruction writing rd
//   i_flush                   pipeline flush (clears scoreboard)
//   o_w_en, o_w, o_w_reg      registered register-file write port
//   o_busy                    per-register pending-write bits
// -----------------------------------------------------------------------------
module nnrv_wb
    import nnrv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_NUM = REG_NUM_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_alu_valid,
    input  logic [4:0]         i_alu_rd,
    input  logic [XLEN-1:0]    i_alu_data,
    output logic               o_alu_ready,
    input  logic               i_ld_valid,
    input  logic [4:0]         i_ld_rd,
    input  logic [2:0]         i_ld_funct3,
    input  logic [XLEN-1:0]    i_ld_data,
    output logic               o_ld_ready,
    input  logic               i_iss_en,
    input  logic [4:0]         i_iss_rd,
    input  logic               i_flush,
    output logic               o_w_en,
    output logic [4:0]         o_w,
    output logic [XLEN-1:0]    o_w_reg,
    output logic [REG_NUM-1:0] o_busy
);

    logic               last_grant_reg, last_grant_next;
    logic               alu_gnt, ld_gnt;
    logic               acc_valid;
    logic [4:0]         acc_rd;
    logic [XLEN-1:0]    acc_data;
    logic [XLEN-1:0]    ld_data_ext;

    logic               w_en_reg,   w_en_next;
    logic [4:0]         w_reg,      w_next;
    logic [XLEN-1:0]    w_data_reg, w_data_next;
    logic [REG_NUM-1:0] busy_reg,   busy_next;

    // ------------------------------------------------------------------
    // Load data path
    // ------------------------------------------------------------------
`ifdef NNRV_WB_LOAD_EXT_EN
    nnrv_wb_ldext #(
        .XLEN     (XLEN)
    ) u_ldext (
        .funct3   (i_ld_funct3),
        .data_in  (i_ld_data),
        .data_out (ld_data_ext)
    );
`else
    // Extension is done by the load unit in this build; funct3 is unused.
    logic unused_ld_funct3;
    assign unused_ld_funct3 = ^i_ld_funct3;
    assign ld_data_ext      = i_ld_data;
`endif

    // ------------------------------------------------------------------
    // Arbitration: a lone valid always wins; on a tie the channel that did
    // not win last time gets the slot. Ready depends only on the valids and
    // last_grant, never on anything downstream.
    // ------------------------------------------------------------------
    always_comb begin
        alu_gnt = i_alu_valid && (!i_ld_valid || (last_grant_reg == GNT_LD));
        ld_gnt  = i_ld_valid  && (!i_alu_valid || (last_grant_reg == GNT_ALU));
    end

    assign o_alu_ready = alu_gnt;
    assign o_ld_ready  = ld_gnt;

    always_comb begin
        acc_valid       = alu_gnt || ld_gnt;
        acc_rd          = ld_gnt ? i_ld_rd     : i_alu_rd;
        acc_data        = ld_gnt ? ld_data_ext : i_alu_data;
        last_grant_next = last_grant_reg;
        if (ld_gnt) begin
            last_grant_next = GNT_LD;
        end else if (alu_gnt) begin
            last_grant_next = GNT_ALU;
        end
    end

    // ------------------------------------------------------------------
    // Write port: x0 results are consumed but never written. Index/data
    // hold when nothing is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_en_next   = acc_valid && (acc_rd != 5'd0);
        w_next      = acc_valid ? acc_rd   : w_reg;
        w_data_next = acc_valid ? acc_data : w_data_reg;
    end

    // ------------------------------------------------------------------
    // Scoreboard: a bit clears on the edge that ends the o_w_en cycle, so it
    // drops exactly when the register file holds the value. A same-edge issue
    // to the same rd is a newer producer and keeps the bit set; flush wipes
    // everything except an issue arriving in the flush cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic iss_hit, wr_hit;
                assign iss_hit = i_iss_en && (i_iss_rd == 5'(gi));
                assign wr_hit  = w_en_reg && (w_reg == 5'(gi));
                assign busy_next[gi] = iss_hit ||
                                       (!i_flush && !wr_hit && busy_reg[gi]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_reg <= GNT_ALU;
            w_en_reg       <= 1'b0;
            w_reg          <= '0;
            w_data_reg     <= '0;
            busy_reg       <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            w_en_reg       <= w_en_next;
            w_reg          <= w_next;
            w_data_reg     <= w_data_next;
            busy_reg       <= busy_next;
        end
    end

    assign o_w_en  = w_en_reg;
    assign o_w     = w_reg;
    assign o_w_reg = w_data_reg;
    assign o_busy  = busy_reg;

endmodule

// File: tb/tb_nnrv_wb.sv
// -----------------------------------------------------------------------------
// tb_nnrv_wb
// Directed bench for nnrv_wb. Stimulus pushes each expected register-file
// write {rd, data} into a queue; a monitor on the falling edge pops and
// compares whenever o_w_en is high. Ready and busy values are checked inline.
// Build with or without NNRV_WB_LOAD_EXT_EN; load expectations follow it.
// -----------------------------------------------------------------------------
module tb_nnrv_wb;

    logic        i_clk;
    logic        i_rst;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [63:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_ld_valid;
    logic [4:0]  i_ld_rd;
    logic [2:0]  i_ld_funct3;
    logic [63:0] i_ld_data;
    logic        o_ld_ready;
    logic        i_iss_en;
    logic [4:0]  i_iss_rd;
    logic        i_flush;
    logic        o_w_en;
    logic [4:0]  o_w;
    logic [63:0] o_w_reg;
    logic [31:0] o_busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [68:0] exp_q[$];

    nnrv_wb #(
        .XLEN    (64),
        .REG_NUM (32)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_alu_valid (i_alu_valid),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .o_alu_ready (o_alu_ready),
        .i_ld_valid  (i_ld_valid),
        .i_ld_rd     (i_ld_rd),
        .i_ld_funct3 (i_ld_funct3),
        .i_ld_data   (i_ld_data),
        .o_ld_ready  (o_ld_ready),
        .i_iss_en    (i_iss_en),
        .i_iss_rd    (i_iss_rd),
        .i_flush     (i_flush),
        .o_w_en      (o_w_en),
        .o_w         (o_w),
        .o_w_reg     (o_w_reg),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One load-only cycle; the channel must be accepted every cycle.
    task automatic ld_vec(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [63:0] data, input logic [63:0] exp);
        i_ld_valid  = 1'b1;
        i_ld_rd     = rd;
        i_ld_funct3 = f3;
        i_ld_data   = data;
        #1;
        chk("ld_ready_single", 64'(o_ld_ready), 64'd1);
        exp_q.push_back({rd, exp});
        tick();
    endtask

    // Write monitor
    always @(negedge i_clk) begin
        if (!i_rst && o_w_en) begin
            logic [68:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", o_w, o_w_reg);
            end else begin
                e = exp_q.pop_front();
                if ({o_w, o_w_reg} !== e) begin
                    miscompares++;
                    $display("FAIL write: got rd=%0d data=%h expected rd=%0d data=%h",
                             o_w, o_w_reg, e[68:64], e[63:0]);
                end else begin
                    $display("ok   write: rd=%0d data=%h", o_w, o_w_reg);
                end
            end
        end
    end

    initial begin
        i_rst       = 1'b1;
        i_alu_valid = 1'b0;
        i_alu_rd    = '0;
        i_alu_data  = '0;
        i_ld_valid  = 1'b0;
        i_ld_rd     = '0;
        i_ld_funct3 = '0;
        i_ld_data   = '0;
        i_iss_en    = 1'b0;
        i_iss_rd    = '0;
        i_flush     = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_w_en",  64'(o_w_en), 64'd0);
        chk("rst_w",     64'(o_w), 64'd0);
        chk("rst_w_reg", o_w_reg, 64'd0);
        chk("rst_busy",  64'(o_busy), 64'd0);

        // Single ALU write rd=5
        i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 64'h1234;
        #1;
        chk("alu_ready_single", 64'(o_alu_ready), 64'd1);
        exp_q.push_back({5'd5, 64'h1234});
        tick();
        i_alu_valid = 1'b0;
        chk("busy_after_alu", 64'(o_busy), 64'd0);

        // Issue rd=7, ALU writes it three cycles later
        i_iss_en = 1'b1; i_iss_rd = 5'd7;
        tick();
        i_iss_en = 1'b0;
        chk("busy7_issued", 64'(o_busy[7]), 64'd1);
        tick();
        tick();
        i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 64'h77;
        exp_q.push_back({5'd7, 64'h77});
        tick();
        i_alu_valid = 1'b0;
        chk("busy7_during_wen", 64'(o_busy[7]), 64'd1);
        tick();
        chk("busy7_cleared", 64'(o_busy[7]), 64'd0);

        // Both channels valid for 4 cycles: load, ALU, load, ALU
        i_alu_valid = 1'b1; i_alu_rd = 5'd1;
        i_ld_valid  = 1'b1; i_ld_rd  = 5'd2; i_ld_funct3 = 3'b011;
        for (int i = 0; i < 4; i++) begin
            i_alu_data = 64'h100 + 64'(i);
            i_ld_data  = 64'h200 + 64'(i);
            #1;
            if (i % 2 == 0) begin
                chk("tie_ld_ready",  64'(o_ld_ready),  64'd1);
                chk("tie_alu_ready", 64'(o_alu_ready), 64'd0);
                exp_q.push_back({5'd2, 64'h200 + 64'(i)});
            end else begin
                chk("tie_ld_ready",  64'(o_ld_ready),  64'd0);
                chk("tie_alu_ready", 64'(o_alu_ready), 64'd1);
                exp_q.push_back({5'd1, 64'h100 + 64'(i)});
            end
            tick();
        end
        i_alu_valid = 1'b0;

        // Back-to-back loads, extension behaviour depends on the build
`ifdef NNRV_WB_LOAD_EXT_EN
        ld_vec(5'd9,  3'b000, 64'h80,                  64'hFFFF_FFFF_FFFF_FF80);
        ld_vec(5'd10, 3'b100, 64'hFF80,                64'h80);
        ld_vec(5'd11, 3'b001, 64'h8000,                64'hFFFF_FFFF_FFFF_8000);
        ld_vec(5'd12, 3'b010, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_8000_0000);
        ld_vec(5'd13, 3'b110, 64'hABCD_0000_8000_0001, 64'h0000_0000_8000_0001);
`else
        ld_vec(5'd9,  3'b000, 64'h80,                  64'h80);
        ld_vec(5'd10, 3'b100, 64'hFF80,                64'hFF80);
        ld_vec(5'd11, 3'b001, 64'h8000,                64'h8000);
        ld_vec(5'd12, 3'b010, 64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000);
        ld_vec(5'd13, 3'b110, 64'hABCD_0000_8000_0001, 64'hABCD_0000_8000_0001);
`endif
        i_ld_valid = 1'b0;

        // rd=0 write is consumed without a write; rd=0 issue never sets busy
        i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 64'hDEAD;
        #1;
        chk("alu_ready_rd0", 64'(o_alu_ready), 64'd1);
        tick();
        i_alu_valid = 1'b0;
        chk("w_en_rd0", 64'(o_w_en), 64'd0);
        i_iss_en = 1'b1; i_iss_rd = 5'd0;
        tick();
        i_iss_en = 1'b0;
        chk("busy_rd0", 64'(o_busy), 64'd0);

        // Same-edge set and clear of rd=3: set wins
        i_iss_en = 1'b1; i_iss_rd = 5'd3;
        tick();
        i_iss_en = 1'b0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 64'h33;
        exp_q.push_back({5'd3, 64'h33});
        tick();
        i_alu_valid = 1'b0;
        i_iss_en = 1'b1; i_iss_rd = 5'd3;
        tick();
        i_iss_en = 1'b0;
        chk("busy3_set_wins", 64'(o_busy), 64'h8);

        // Flush with issue rd=4 and an accepted ALU write that must still land
        i_flush = 1'b1; i_iss_en = 1'b1; i_iss_rd = 5'd4;
        i_alu_valid = 1'b1; i_alu_rd = 5'd6; i_alu_data = 64'h66;
        exp_q.push_back({5'd6, 64'h66});
        tick();
        i_flush = 1'b0; i_iss_en = 1'b0; i_alu_valid = 1'b0;
        chk("busy_flush_iss4", 64'(o_busy), 64'h10);
        tick();

        // Reset mid-operation: accepted result discarded, scoreboard cleared
        i_alu_valid = 1'b1; i_alu_rd = 5'd8; i_alu_data = 64'h88;
        i_iss_en = 1'b1; i_iss_rd = 5'd8;
        tick();
        i_alu_valid = 1'b0; i_iss_en = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("midrst_w_en",  64'(o_w_en), 64'd0);
        chk("midrst_w",     64'(o_w), 64'd0);
        chk("midrst_w_reg", o_w_reg, 64'd0);
        chk("midrst_busy",  64'(o_busy), 64'd0);
        tick();
        i_rst = 1'b0;
        tick();

        // After reset the tie-break restarts with load first
        i_alu_valid = 1'b1; i_alu_rd = 5'd14; i_alu_data = 64'hA;
        i_ld_valid  = 1'b1; i_ld_rd  = 5'd15; i_ld_funct3 = 3'b011; i_ld_data = 64'hB;
        #1;
        chk("postrst_ld_ready", 64'(o_ld_ready), 64'd1);
        exp_q.push_back({5'd15, 64'hB});
        tick();
        i_alu_valid = 1'b0; i_ld_valid = 1'b0;

        // Drain the expected-write queue within a bounded number of cycles
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
